ifetch_prefetch: RTL

IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

---
 rtl/ifetch_prefetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: issues sequential ROM reads into a small FIFO feeding the core,
// with epoch-tagged in-flight reads so redirects can discard stale returns.
module ifetch_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int ROM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              out_rom_enable,
  output logic [ADDR_W-1:0] out_rom_address,
  input  logic [DATA_W-1:0] in_rom_data,
  output logic              core_valid,
  output logic [DATA_W-1:0] core_inst,
  output logic [ADDR_W-1:0] core_pc,
  input  logic              core_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int EPW = (ROM_LAT > 1) ? $clog2(ROM_LAT) + 1 : 1;
  localparam int CW = $clog2(DEPTH + ROM_LAT + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  logic [ADDR_W-1:0] r_fpc;
  logic [EPW-1:0]    r_epoch;
  logic [ROM_LAT-1:0] r_pv;
  logic [EPW-1:0]    r_pe [ROM_LAT];
  logic [ADDR_W-1:0] r_ppc [ROM_LAT];
  logic [DATA_W-1:0] r_mem_inst [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc [DEPTH];
  logic [PW:0]       r_wr;
  logic [PW:0]       r_rd;

  logic              w_empty;
  logic [PW:0]       w_occ;
  logic              w_pop;
  logic [CW-1:0]     w_inflight;
  logic              w_credit;
  logic              w_issue;
  logic              w_ret_ok;

  assign w_empty = (r_wr == r_rd);
  assign w_occ   = r_wr - r_rd;
  assign w_pop   = !w_empty && core_ready;

  // In-flight count covers every pipe slot, stale or not, so credit is never over-granted.
  always_comb begin
    w_inflight = {CW{1'b0}};
    for (int i = 0; i < ROM_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_pv[i]);
    end
  end

  // Occupancy is taken after this cycle's head transfer so a full pipe still streams.
  assign w_credit = (CW'(w_occ) - CW'(w_pop) + w_inflight) < CW'(DEPTH);
  assign w_issue  = !rst && !redirect_valid && w_credit;
  assign w_ret_ok = r_pv[ROM_LAT-1] && (r_pe[ROM_LAT-1] == r_epoch) && !redirect_valid;

  assign out_rom_enable  = w_issue;
  assign out_rom_address = r_fpc;
  assign core_valid      = !w_empty;
  assign core_inst       = w_empty ? {DATA_W{1'b0}} : r_mem_inst[r_rd[PW-1:0]];
  assign core_pc         = w_empty ? {ADDR_W{1'b0}} : r_mem_pc[r_rd[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc   <= RESET_PC;
      r_epoch <= {EPW{1'b0}};
      r_pv    <= {ROM_LAT{1'b0}};
      r_wr    <= {(PW + 1){1'b0}};
      r_rd    <= {(PW + 1){1'b0}};
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pe[i]  <= {EPW{1'b0}};
        r_ppc[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      for (int i = ROM_LAT - 1; i > 0; i--) begin
        r_pv[i]  <= r_pv[i-1];
        r_pe[i]  <= r_pe[i-1];
        r_ppc[i] <= r_ppc[i-1];
      end
      r_pv[0]  <= w_issue;
      r_pe[0]  <= r_epoch;
      r_ppc[0] <= r_fpc;
      if (redirect_valid) begin
        r_fpc   <= redirect_pc;
        r_epoch <= r_epoch + EPW'(1);
        r_wr    <= {(PW + 1){1'b0}};
        r_rd    <= {(PW + 1){1'b0}};
      end else begin
        if (w_issue) begin
          r_fpc <= r_fpc + STEP;
        end
        if (w_ret_ok) begin
          r_wr <= r_wr + (PW + 1)'(1);
        end
        if (w_pop) begin
          r_rd <= r_rd + (PW + 1)'(1);
        end
      end
    end
  end

  // FIFO storage is datapath only; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_ret_ok) begin
      r_mem_inst[r_wr[PW-1:0]] <= in_rom_data;
      r_mem_pc[r_wr[PW-1:0]]   <= r_ppc[ROM_LAT-1];
    end
  end

endmodule
